// File: rtl/vga_color_scheduler.sv
// Frame-synchronous colour scheduler: round-robin admits one 3-bit update, applied at the next vsync boundary.
// Latency: grant pulse 1 cycle after req is sampled; rgb_sw/applied update on the clock edge that sees the frame boundary.
// Backpressure: while an update is pending no further grants are issued; requesters hold req until their gnt.
module vga_color_scheduler #(
    parameter int         FRAMES_PER_STEP  = 60,
    parameter logic [2:0] RESET_RGB        = 3'b111,
    parameter bit         VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic [2:0] cfg0,
    input  logic       req1,
    input  logic [2:0] cfg1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       vsync,
    input  logic       auto_en,
    output logic [2:0] rgb_sw,
    output logic       pending,
    output logic       applied
);

    localparam int              CW         = $clog2(FRAMES_PER_STEP) + 1;
    localparam logic [CW-1:0]   CNT_MAX    = CW'(FRAMES_PER_STEP - 1);
    localparam logic            ACTIVE_LVL = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t        state_q, state_d;
    logic          vsync_d;
    logic          fb;
    logic          last_q, last_d;   // 1: requester 1 was granted last
    logic          pick0;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    rgb_d;
    logic          gnt0_d, gnt1_d, applied_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign fb      = (vsync == ACTIVE_LVL) && (vsync_d != ACTIVE_LVL);
    assign pending = (state_q == PENDING);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pend_d    = pend_q;
        rgb_d     = rgb_sw;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        applied_d = 1'b0;
        pick0     = 1'b0;
        cnt_d     = auto_en ? cnt_q : '0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention, the requester not granted last wins.
                    pick0   = req0 && (!req1 || last_q);
                    gnt0_d  = pick0;
                    gnt1_d  = !pick0;
                    pend_d  = pick0 ? cfg0 : cfg1;
                    last_d  = !pick0;
                    state_d = PENDING;
                end else if (fb && auto_en) begin
                    if (cnt_q == CNT_MAX) begin
                        rgb_d = rgb_sw + 3'd1;
                        cnt_d = '0;
                    end else if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = CNT_MAX;
                    end
                end
            end
            PENDING: begin
                if (fb) begin
                    rgb_d     = pend_q;
                    applied_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vsync_d <= ~ACTIVE_LVL;
            last_q  <= 1'b1;
            pend_q  <= '0;
            rgb_sw  <= RESET_RGB;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            applied <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vsync_d <= vsync;
            last_q  <= last_d;
            pend_q  <= pend_d;
            rgb_sw  <= rgb_d;
            gnt0    <= gnt0_d;
            gnt1    <= gnt1_d;
            applied <= applied_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
